// File: rtl/message_serializer_pkg.sv
// rtl/message_serializer_pkg.sv - shared types and helpers for the message serializer
// The CHECKSUM state exists only when SERIALIZER_CHECKSUM_EN is defined.
package message_serializer_pkg;

  localparam logic [7:0] START_BYTE_DEFAULT = 8'hA5;
  localparam int         MAX_MSG_LENGTH     = 256;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_PAYLOAD,
`ifdef SERIALIZER_CHECKSUM_EN
    S_CHECKSUM,
`endif
    S_DONE
  } ser_state_t;

  // XOR of the low num_bytes bytes of msg, i.e. all payload bytes of a message.
  function automatic logic [7:0] xor_bytes(input logic [MAX_MSG_LENGTH-1:0] msg,
                                           input int num_bytes);
    logic [7:0] acc;
    acc = 8'h00;
    for (int k = 0; k < MAX_MSG_LENGTH / 8; k++) begin
      if (k < num_bytes) acc = acc ^ msg[8*k +: 8];
    end
    return acc;
  endfunction

endpackage

// File: rtl/message_serializer_if.sv
// rtl/message_serializer_if.sv - byte stream between the serializer and the UART transmitter
interface message_serializer_if;

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (output byte_valid, output byte_data, input byte_ready);
  modport slave  (input byte_valid, input byte_data, output byte_ready);

endinterface

// File: rtl/message_shift_register.sv
// rtl/message_shift_register.sv - message holding register, parallel load and shift-left-by-8
module message_shift_register #(
  parameter int WIDTH = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  output logic [7:0]       top_byte
);

  logic [WIDTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= load_data;
    end else if (shift) begin
      sr <= sr << 8;
    end
  end

  assign top_byte = sr[WIDTH-1 -: 8];

endmodule

// File: rtl/message_serializer.sv
// rtl/message_serializer.sv - frames a message as START_BYTE, payload MSB-first, optional XOR checksum
// SERIALIZER_CHECKSUM_EN appends the checksum byte after the payload.
module message_serializer
  import message_serializer_pkg::*;
#(
  parameter int         MSG_LENGTH = 48,
  parameter logic [7:0] START_BYTE = START_BYTE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  send_data,
  input  logic [MSG_LENGTH-1:0] tx_data,
  output logic                  data_sent,
  output logic                  busy,
  message_serializer_if.master  bus
);

  localparam int NUM_BYTES = MSG_LENGTH / 8;
  localparam int CNT_W     = $clog2(NUM_BYTES + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

  ser_state_t            state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic                  send_q;
  logic                  send_rise;
  logic                  pend_valid;
  logic [MSG_LENGTH-1:0] pend_data;
  logic                  load, shift, take_pend;
  logic [MSG_LENGTH-1:0] load_data;
  logic [7:0]            top_byte;
  logic                  byte_valid_c;
  logic [7:0]            byte_data_c;

  assign send_rise = send_data & ~send_q;

  message_shift_register #(.WIDTH(MSG_LENGTH)) u_shift (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .shift     (shift),
    .top_byte  (top_byte)
  );

`ifdef SERIALIZER_CHECKSUM_EN
  logic [7:0] checksum;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      checksum <= 8'h00;
    end else if (shift) begin
      checksum <= checksum ^ top_byte;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      send_q     <= 1'b0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      send_q <= send_data;
      // Only one request may wait behind the active frame; later ones are dropped.
      if (take_pend) begin
        pend_valid <= 1'b0;
      end else if (send_rise && byte_valid_c && !pend_valid) begin
        pend_valid <= 1'b1;
        pend_data  <= tx_data;
      end
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    load         = 1'b0;
    load_data    = tx_data;
    shift        = 1'b0;
    take_pend    = 1'b0;
    byte_valid_c = 1'b0;
    byte_data_c  = 8'h00;
    data_sent    = 1'b0;
    case (state)
      S_IDLE: begin
        if (send_rise) begin
          load    = 1'b1;
          state_n = S_START;
        end
      end
      S_START: begin
        byte_valid_c = 1'b1;
        byte_data_c  = START_BYTE;
        if (bus.byte_ready) begin
          cnt_n   = '0;
          state_n = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        byte_valid_c = 1'b1;
        byte_data_c  = top_byte;
        if (bus.byte_ready) begin
          shift = 1'b1;
          cnt_n = cnt + CNT_W'(1);
          if (cnt == LAST_IDX) begin
`ifdef SERIALIZER_CHECKSUM_EN
            state_n = S_CHECKSUM;
`else
            state_n = S_DONE;
`endif
          end
        end
      end
`ifdef SERIALIZER_CHECKSUM_EN
      S_CHECKSUM: begin
        byte_valid_c = 1'b1;
        byte_data_c  = checksum;
        if (bus.byte_ready) state_n = S_DONE;
      end
`endif
      S_DONE: begin
        data_sent = 1'b1;
        // Back-to-back frames skip IDLE so the link never idles with work queued.
        if (pend_valid) begin
          load      = 1'b1;
          load_data = pend_data;
          take_pend = 1'b1;
          state_n   = S_START;
        end else if (send_rise) begin
          load    = 1'b1;
          state_n = S_START;
        end else begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign busy           = (state != S_IDLE);
  assign bus.byte_valid = byte_valid_c;
  assign bus.byte_data  = byte_data_c;

endmodule
